// File: rtl/add4_lcd_frame_feeder_pkg.sv
// rtl/add4_lcd_frame_feeder_pkg.sv - shared states, LCD command/ASCII constants and decimal helpers
`timescale 1ns/1ps
package add4_lcd_pkg;

  localparam int LINE_LEN_DEF = 16;
  localparam int IDX_W        = 6;

  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CMD_CLEAR = 8'h01;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_U    = 8'h55;
  localparam logic [7:0] ASCII_M    = 8'h4D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_L1_ADDR,
    ST_L1_CHAR,
    ST_L2_ADDR,
    ST_L2_CHAR,
    ST_DONE
  } state_t;

  // Values never exceed 31, so three thresholds cover every tens digit.
  function automatic logic [1:0] dec_tens(input logic [4:0] v);
    if (v >= 5'd30)      return 2'd3;
    else if (v >= 5'd20) return 2'd2;
    else if (v >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  function automatic logic [3:0] dec_units(input logic [4:0] v);
    case (dec_tens(v))
      2'd3:    return 4'(v - 5'd30);
      2'd2:    return 4'(v - 5'd20);
      2'd1:    return 4'(v - 5'd10);
      default: return v[3:0];
    endcase
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_0 + {4'b0000, d};
  endfunction

endpackage

// File: rtl/add4_lcd_frame_feeder_if.sv
// rtl/add4_lcd_frame_feeder_if.sv - byte stream towards the LCD nibble writer
`timescale 1ns/1ps
interface add4_lcd_frame_feeder_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_rs;

  modport master (output out_valid, output out_byte, output out_rs, input out_ready);
  modport slave  (input out_valid, input out_byte, input out_rs, output out_ready);
endinterface

// File: rtl/add4_lcd_frame_feeder_char_fmt.sv
// rtl/add4_lcd_frame_feeder_char_fmt.sv - combinational character generator for both text lines
`timescale 1ns/1ps
module add4_lcd_char_fmt
  import add4_lcd_pkg::*;
#(
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic             line,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  input  logic             cin,
  input  logic [4:0]       sum,
  output logic [7:0]       ch
);

  // Line 1 is "AA+BB+C=SS", line 2 is "SUM=" plus the sum in binary; the rest pads.
  always_comb begin
    ch = PAD_CHAR;
    if (!line) begin
      case (idx)
        6'd0: ch = digit_char({2'b00, dec_tens({1'b0, op_a})});
        6'd1: ch = digit_char(dec_units({1'b0, op_a}));
        6'd2: ch = ASCII_PLUS;
        6'd3: ch = digit_char({2'b00, dec_tens({1'b0, op_b})});
        6'd4: ch = digit_char(dec_units({1'b0, op_b}));
        6'd5: ch = ASCII_PLUS;
        6'd6: ch = digit_char({3'b000, cin});
        6'd7: ch = ASCII_EQ;
        6'd8: ch = digit_char({2'b00, dec_tens(sum)});
        6'd9: ch = digit_char(dec_units(sum));
        default: ch = PAD_CHAR;
      endcase
    end else begin
      case (idx)
        6'd0: ch = ASCII_S;
        6'd1: ch = ASCII_U;
        6'd2: ch = ASCII_M;
        6'd3: ch = ASCII_EQ;
        6'd4: ch = digit_char({3'b000, sum[4]});
        6'd5: ch = digit_char({3'b000, sum[3]});
        6'd6: ch = digit_char({3'b000, sum[2]});
        6'd7: ch = digit_char({3'b000, sum[1]});
        6'd8: ch = digit_char({3'b000, sum[0]});
        default: ch = PAD_CHAR;
      endcase
    end
  end

endmodule

// File: rtl/add4_lcd_frame_feeder.sv
// rtl/add4_lcd_frame_feeder.sv - formats the add4 result as a 2-line LCD frame (LCD_CLEAR_EN adds a clear command)
`timescale 1ns/1ps
module add4_lcd_frame_feeder
  import add4_lcd_pkg::*;
#(
  parameter int         LINE_LEN = LINE_LEN_DEF,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [3:0]                      op_a,
  input  logic [3:0]                      op_b,
  input  logic                            cin,
  output logic                            busy,
  output logic                            frame_done,
  add4_lcd_frame_feeder_if.master         lcd
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LEN - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [3:0]       a_q, b_q;
  logic             cin_q;
  logic [4:0]       sum_q;
  logic [7:0]       fmt_ch;

  add4_lcd_char_fmt #(.PAD_CHAR(PAD_CHAR)) u_fmt (
    .line (state == ST_L2_CHAR),
    .idx  (idx),
    .op_a (a_q),
    .op_b (b_q),
    .cin  (cin_q),
    .sum  (sum_q),
    .ch   (fmt_ch)
  );

  // State, character index and the operand/sum snapshot for the frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sum_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == ST_IDLE && start) begin
        a_q   <= op_a;
        b_q   <= op_b;
        cin_q <= cin;
      end
      if (state == ST_LOAD)
        sum_q <= {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};
    end
  end

  // Next state and stream outputs; every emitting state holds its byte until out_ready.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    lcd.out_valid = 1'b0;
    lcd.out_byte  = 8'h00;
    lcd.out_rs    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
`ifdef LCD_CLEAR_EN
        state_nx = ST_CLEAR;
`else
        state_nx = ST_L1_ADDR;
`endif
      end
`ifdef LCD_CLEAR_EN
      ST_CLEAR: begin
        lcd.out_valid = 1'b1;
        lcd.out_byte  = CMD_CLEAR;
        if (lcd.out_ready) state_nx = ST_L1_ADDR;
      end
`endif
      ST_L1_ADDR: begin
        lcd.out_valid = 1'b1;
        lcd.out_byte  = CMD_LINE1;
        if (lcd.out_ready) state_nx = ST_L1_CHAR;
      end
      ST_L1_CHAR: begin
        lcd.out_valid = 1'b1;
        lcd.out_byte  = fmt_ch;
        lcd.out_rs    = 1'b1;
        if (lcd.out_ready) begin
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = ST_L2_ADDR;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_L2_ADDR: begin
        lcd.out_valid = 1'b1;
        lcd.out_byte  = CMD_LINE2;
        if (lcd.out_ready) state_nx = ST_L2_CHAR;
      end
      ST_L2_CHAR: begin
        lcd.out_valid = 1'b1;
        lcd.out_byte  = fmt_ch;
        lcd.out_rs    = 1'b1;
        if (lcd.out_ready) begin
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = ST_DONE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule
